rr_grant_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among `N` requesters using a req/gnt handshake with a registered one-hot grant. Each grant is held until the owner drops its request. A hold watchdog forces release after `MAX_HOLD` cycles. The block sits in front of any shared datapath in the assertion test benches and carries its own SVA protocol checkers.

---
 rtl/rr_grant_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// Round-robin req/gnt arbiter with registered one-hot grant, hold watchdog and a mandatory gap cycle.
// Define RR_ARB_ASSERT_EN to compile the protocol checker bound inside the block.
module rr_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);
    localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [IW-1:0]  ptr_r, ptr_s;
    logic [HW-1:0]  hcnt_r, hcnt_s;
    logic [N-1:0]   gnt_r, gnt_s;
    logic [IW-1:0]  gnt_id_r, gnt_id_s;
    logic           busy_r, busy_s;
    logic           timeout_r, timeout_s;
    logic [IW:0]    pick_s;
    logic [IW-1:0]  ptr_next_s;

    // First requester at or after p, wrapping modulo N; MSB of the result flags a hit.
    function automatic logic [IW:0] pick_first(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic          found;
        logic [IW-1:0] idx;
        int            j;
        found = 1'b0;
        idx   = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            j = (int'(p) + i) % N;
            if (!found && r[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        return {found, idx};
    endfunction

    // Arbitration search and pointer rotation past the current owner.
    always_comb begin
        pick_s     = pick_first(req, ptr_r);
        ptr_next_s = (gnt_id_r == IW'(N - 1)) ? {IW{1'b0}} : gnt_id_r + IW'(1);
    end

    // Next-state and next-output logic for the IDLE/GRANT/GAP controller.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        hcnt_s    = hcnt_r;
        gnt_s     = gnt_r;
        gnt_id_s  = gnt_id_r;
        busy_s    = busy_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[IW]) begin
                    gnt_s    = ONE << pick_s[IW-1:0];
                    gnt_id_s = pick_s[IW-1:0];
                    busy_s   = 1'b1;
                    hcnt_s   = {HW{1'b0}};
                    state_s  = ST_GRANT;
                end else begin
                    gnt_s  = {N{1'b0}};
                    busy_s = 1'b0;
                end
            end
            ST_GRANT: begin
                // A same-edge request drop wins over the watchdog, so no timeout then.
                if (!req[gnt_id_r]) begin
                    gnt_s   = {N{1'b0}};
                    busy_s  = 1'b0;
                    ptr_s   = ptr_next_s;
                    state_s = ST_GAP;
                end else if (hcnt_r == HMAX) begin
                    gnt_s     = {N{1'b0}};
                    busy_s    = 1'b0;
                    ptr_s     = ptr_next_s;
                    timeout_s = 1'b1;
                    state_s   = ST_GAP;
                end else begin
                    hcnt_s = hcnt_r + HW'(1);
                end
            end
            ST_GAP: begin
                gnt_s   = {N{1'b0}};
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                gnt_s   = {N{1'b0}};
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the grant without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {IW{1'b0}};
            hcnt_r    <= {HW{1'b0}};
            gnt_r     <= {N{1'b0}};
            gnt_id_r  <= {IW{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            hcnt_r    <= hcnt_s;
            gnt_r     <= gnt_s;
            gnt_id_r  <= gnt_id_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

`ifdef RR_ARB_ASSERT_EN
    rr_grant_arbiter_chk #(.N(N), .MAX_HOLD(MAX_HOLD)) u_chk (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt_r),
        .gnt_id (gnt_id_r),
        .busy   (busy_r)
    );
`else
    // Protocol checker not compiled in this build.
`endif
endmodule

`ifdef RR_ARB_ASSERT_EN
// Concurrent protocol checks for rr_grant_arbiter.
module rr_grant_arbiter_chk #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input logic                 clk,
    input logic                 rst,
    input logic [N-1:0]         req,
    input logic [N-1:0]         gnt,
    input logic [$clog2(N)-1:0] gnt_id,
    input logic                 busy
);
    logic [N-1:0] req_q_r;

    // Request vector seen on the edge that issued the grant, indexed by the new owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q_r <= {N{1'b0}};
        end else begin
            req_q_r <= req;
        end
    end

    // busy is sampled high on MAX_HOLD edges, so release shows up at offset MAX_HOLD at the latest.
    sequence s_release(bit b_busy);
        ##[0:MAX_HOLD] !b_busy;
    endsequence

    property p_owner(bit b_busy, bit b_gnt);
        b_busy |-> b_gnt;
    endproperty

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
        $info("a_onehot pass"); else $error("a_onehot violated");
    a_rose: assert property (@(posedge clk) disable iff (rst) $rose(busy) |-> req_q_r[gnt_id])
        $info("a_rose pass"); else $error("a_rose violated");
    a_owner: assert property (@(posedge clk) disable iff (rst) p_owner(busy, gnt[gnt_id]))
        $info("a_owner pass"); else $error("a_owner violated");
    a_gap: assert property (@(posedge clk) disable iff (rst) $fell(busy) |=> !busy)
        $info("a_gap pass"); else $error("a_gap violated");
    a_hold: assert property (@(posedge clk) disable iff (rst) busy |-> s_release(busy))
        $info("a_hold pass"); else $error("a_hold violated");
endmodule
`endif

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (N=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_grant_arbiter;
    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int n_total = 0;
    int n_bad   = 0;

    rr_grant_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant edge, `hold` owner cycles, owner drops req, GAP cycle, back in IDLE.
    task automatic grant_cycle(input int id, input int hold, input bit restore);
        logic [N-1:0] exp_g;
        exp_g = 4'b0001 << id;
        tick();
        for (int c = 0; c < hold; c++) begin
            chk("own_gnt", 32'(gnt), 32'(exp_g));
            chk("own_id", 32'(gnt_id), 32'(id));
            chk("own_busy", 32'(busy), 32'd1);
            chk("own_timeout", 32'(timeout), 32'd0);
            if (c < hold - 1) tick();
        end
        req[id] = 1'b0;
        tick();
        chk("gap_gnt", 32'(gnt), 32'd0);
        chk("gap_busy", 32'(busy), 32'd0);
        chk("rel_timeout", 32'(timeout), 32'd0);
        if (restore) req[id] = 1'b1;
        tick();
        chk("idle_gnt", 32'(gnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_id", 32'(gnt_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_noreq", 32'(gnt), 32'd0);

        // Rotation from ptr=0 under full contention.
        req = 4'b1111;
        grant_cycle(0, 2, 1'b1);
        grant_cycle(1, 2, 1'b1);
        grant_cycle(2, 2, 1'b1);
        grant_cycle(3, 2, 1'b1);
        grant_cycle(0, 2, 1'b0);
        req = 4'b0000;

        // Single request: ptr=1 -> requester 2, held 3 cycles; ptr becomes 3.
        req = 4'b0100;
        grant_cycle(2, 3, 1'b0);

        // Wrap-around from ptr=3: requester 0, then 1.
        req = 4'b0011;
        grant_cycle(0, 2, 1'b0);
        grant_cycle(1, 2, 1'b0);

        // Watchdog: requester 0 held; forced release after exactly MH cycles.
        req = 4'b0001;
        tick();
        for (int c = 0; c < MH; c++) begin
            chk("wd_gnt", 32'(gnt), 32'h1);
            chk("wd_timeout_low", 32'(timeout), 32'd0);
            if (c < MH - 1) tick();
        end
        tick();
        chk("wd_release_gnt", 32'(gnt), 32'd0);
        chk("wd_timeout_pulse", 32'(timeout), 32'd1);
        chk("wd_release_busy", 32'(busy), 32'd0);
        tick();
        chk("wd_gap_gnt", 32'(gnt), 32'd0);
        chk("wd_timeout_once", 32'(timeout), 32'd0);
        tick();
        chk("wd_regrant", 32'(gnt), 32'h1);
        chk("wd_regrant_timeout", 32'(timeout), 32'd0);
        tick();
        chk("wd_regrant_hold", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk("wd_drop_gnt", 32'(gnt), 32'd0);
        tick();

        // Requester 1 drops req on the same edge the hold counter hits its limit.
        req = 4'b0010;
        grant_cycle(1, 8, 1'b0);

        // Reset in the middle of requester 3's grant.
        req = 4'b1000;
        tick();
        chk("pre_rst_gnt", 32'(gnt), 32'h8);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        chk("async_rst_id", 32'(gnt_id), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_timeout", 32'(timeout), 32'd0);
        req = 4'b1001;
        tick();
        chk("in_rst_gnt", 32'(gnt), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_id", 32'(gnt_id), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
